// File: rtl/ptp_td_tx_ser_if.sv
// Snapshot handshake and serial-output bundle for the PTP ToD link transmitter.
// master drives the snapshot; slave is the serializer.
interface ptp_td_tx_ser_if;
  logic        in_ts_sel;
  logic [31:0] in_rel_ns;
  logic [47:0] in_tod_s;
  logic [31:0] in_offset_ns;
  logic [47:0] in_alt_tod_s;
  logic [31:0] in_alt_offset_ns;
  logic        in_valid;
  logic        in_ready;
  logic        ptp_td_sdo;
  logic        busy;
  logic        frame_done;

  modport master (
    output in_ts_sel, in_rel_ns, in_tod_s, in_offset_ns, in_alt_tod_s, in_alt_offset_ns,
    output in_valid,
    input  in_ready, ptp_td_sdo, busy, frame_done
  );

  modport slave (
    input  in_ts_sel, in_rel_ns, in_tod_s, in_offset_ns, in_alt_tod_s, in_alt_offset_ns,
    input  in_valid,
    output in_ready, ptp_td_sdo, busy, frame_done
  );
endinterface

// File: rtl/ptp_td_tx_ser.sv
// PTP time-distribution serializer: one ToD snapshot becomes three framed messages
// (6, 3 and 6 words of start + 16 LSB-first bits) on a registered, idle-high line.
module ptp_td_tx_ser #(
  parameter int unsigned MSG_GAP   = 1,
  parameter int unsigned RST_FLUSH = 17
) (
  input logic             ptp_clk,
  input logic             rst,
  ptp_td_tx_ser_if.slave  tx
);

  localparam int unsigned FlushW = (RST_FLUSH < 2) ? 1 : $clog2(RST_FLUSH + 1);
  localparam int unsigned GapW   = (MSG_GAP < 2) ? 1 : $clog2(MSG_GAP);
  localparam logic [FlushW-1:0] FlushInit = FlushW'(RST_FLUSH);
  localparam logic [GapW-1:0]   GapLast   = GapW'(MSG_GAP - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StGap} state_e;

  state_e            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [2:0]        word_idx_q, word_idx_d;
  logic [1:0]        msg_idx_q, msg_idx_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [FlushW-1:0] flush_q, flush_d;
  logic              sdo_q, sdo_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic              ts_sel_q;
  logic [31:0]       rel_ns_q, offset_ns_q, alt_offset_ns_q;
  logic [47:0]       tod_s_q, alt_tod_s_q;

  logic              in_ready;
  logic              load;
  logic [2:0]        last_word;
  logic [15:0]       cur_word;

  assign in_ready      = (state_q == StIdle) && (flush_q == '0);
  assign tx.in_ready   = in_ready;
  assign tx.ptp_td_sdo = sdo_q;
  assign tx.busy       = busy_q;
  assign tx.frame_done = frame_done_q;

  assign last_word = (msg_idx_q == 2'd1) ? 3'd2 : 3'd5;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    word_idx_d   = word_idx_q;
    msg_idx_d    = msg_idx_q;
    gap_cnt_d    = gap_cnt_q;
    flush_d      = (flush_q != '0) ? flush_q - FlushW'(1) : flush_q;
    frame_done_d = 1'b0;
    load         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tx.in_valid && in_ready) begin
          load       = 1'b1;
          state_d    = StStart;
          word_idx_d = 3'd0;
          msg_idx_d  = 2'd0;
        end
      end
      StStart: begin
        state_d   = StData;
        bit_cnt_d = 4'd0;
      end
      StData: begin
        if (bit_cnt_q == 4'd15) begin
          if (word_idx_q != last_word) begin
            state_d    = StStart;
            word_idx_d = word_idx_q + 3'd1;
          end else if (msg_idx_q == 2'd2) begin
            // Final stop bit is driven from IDLE so a queued snapshot can start next cycle.
            state_d      = StIdle;
            frame_done_d = 1'b1;
          end else begin
            state_d = StStop;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      StStop: begin
        msg_idx_d  = msg_idx_q + 2'd1;
        word_idx_d = 3'd0;
        gap_cnt_d  = '0;
        state_d    = (MSG_GAP == 0) ? StStart : StGap;
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StStart;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Word 0 carries the message type in [3:0] and ts_sel in [9].
  always_comb begin
    cur_word = '0;
    if (word_idx_d == 3'd0) begin
      cur_word[1:0] = msg_idx_d;
      cur_word[9]   = ts_sel_q;
    end else begin
      case ({msg_idx_d, word_idx_d})
        {2'd0, 3'd1}: cur_word = rel_ns_q[15:0];
        {2'd0, 3'd2}: cur_word = rel_ns_q[31:16];
        {2'd0, 3'd3}: cur_word = tod_s_q[15:0];
        {2'd0, 3'd4}: cur_word = tod_s_q[31:16];
        {2'd0, 3'd5}: cur_word = tod_s_q[47:32];
        {2'd1, 3'd1}: cur_word = offset_ns_q[15:0];
        {2'd1, 3'd2}: cur_word = offset_ns_q[31:16];
        {2'd2, 3'd1}: cur_word = alt_offset_ns_q[15:0];
        {2'd2, 3'd2}: cur_word = alt_offset_ns_q[31:16];
        {2'd2, 3'd3}: cur_word = alt_tod_s_q[15:0];
        {2'd2, 3'd4}: cur_word = alt_tod_s_q[31:16];
        {2'd2, 3'd5}: cur_word = alt_tod_s_q[47:32];
        default:      cur_word = '0;
      endcase
    end
  end

  always_comb begin
    sdo_d  = 1'b1;
    busy_d = (state_d != StIdle);
    unique case (state_d)
      StStart: sdo_d = 1'b0;
      StData:  sdo_d = cur_word[bit_cnt_d];
      default: sdo_d = 1'b1;
    endcase
  end

  always_ff @(posedge ptp_clk) begin
    if (rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      word_idx_q   <= '0;
      msg_idx_q    <= '0;
      gap_cnt_q    <= '0;
      flush_q      <= FlushInit;
      sdo_q        <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_idx_q   <= word_idx_d;
      msg_idx_q    <= msg_idx_d;
      gap_cnt_q    <= gap_cnt_d;
      flush_q      <= flush_d;
      sdo_q        <= sdo_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Shadow copy is only read while busy, so it needs no reset.
  always_ff @(posedge ptp_clk) begin
    if (load) begin
      ts_sel_q        <= tx.in_ts_sel;
      rel_ns_q        <= tx.in_rel_ns;
      tod_s_q         <= tx.in_tod_s;
      offset_ns_q     <= tx.in_offset_ns;
      alt_tod_s_q     <= tx.in_alt_tod_s;
      alt_offset_ns_q <= tx.in_alt_offset_ns;
    end
  end

endmodule
